// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The depth/width constants are also used by the instruction store itself.
package imem_pkg;

  localparam int IMEM_DEPTH  = 256;
  localparam int IMEM_ADDR_W = 8;
  localparam int INSTR_W     = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs bytes MSB-first into a 32-bit word. A 2-bit counter flags the 4th byte.
// Ports: clk, reset, shift_en, clear, byte_in[7:0] -> word_out[31:0], last_byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               clear,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word_out,
  output logic               last_byte
);

  logic [INSTR_W-1:0] r_word;
  logic [1:0]         r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (shift_en) begin
      r_word <= {r_word[INSTR_W-9:0], byte_in};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  assign word_out  = r_word;
  assign last_byte = (r_cnt == 2'd3) && shift_en;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into the instruction store as 32-bit words.
// Ports: byte stream in (byte_valid/ready/data), write port out (wr_*), status.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    word_count
);

  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

  state_t r_state;
  state_t w_next;

  logic [15:0]     r_len;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W:0] r_word_count;
  logic            r_error;

  logic            w_ready;
  logic            w_xfer;
  logic            w_shift;
  logic            w_clear;
  logic            w_last;
  logic [15:0]     w_len_full;
  logic            w_len_ovf;
  logic [ADDR_W:0] w_cnt_inc;
  logic            w_final;

  assign w_ready = (r_state == LEN_HI) ||
                   (r_state == LEN_LO) ||
                   (r_state == DATA);
  assign w_xfer  = byte_valid && w_ready;
  assign w_shift = w_xfer && (r_state == DATA);
  assign w_clear = start && (r_state == IDLE);

  // Length as it will be once the low byte in flight is captured.
  assign w_len_full = {r_len[15:8], byte_data};
  assign w_len_ovf  = {1'b0, w_len_full} > LP_DEPTH;
  assign w_cnt_inc  = r_word_count + 1'b1;
  assign w_final    = 17'(w_cnt_inc) == {1'b0, r_len};

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (w_shift),
    .clear     (w_clear),
    .byte_in   (byte_data),
    .word_out  (wr_data),
    .last_byte (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    wr_en  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = LEN_HI;
      end
      LEN_HI: begin
        busy = 1'b1;
        if (w_xfer) w_next = LEN_LO;
      end
      LEN_LO: begin
        busy = 1'b1;
        if (w_xfer) begin
          if (w_len_full == 16'd0) w_next = DONE;
          else if (w_len_ovf)      w_next = IDLE;
          else                     w_next = DATA;
        end
      end
      DATA: begin
        busy = 1'b1;
        if (w_last) w_next = WRITE;
      end
      WRITE: begin
        busy   = 1'b1;
        wr_en  = 1'b1;
        w_next = w_final ? DONE : DATA;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len        <= '0;
      r_wr_addr    <= '0;
      r_word_count <= '0;
      r_error      <= 1'b0;
    end else begin
      if (w_clear) begin
        r_wr_addr    <= '0;
        r_word_count <= '0;
        r_error      <= 1'b0;
      end
      if (w_xfer && (r_state == LEN_HI)) begin
        r_len[15:8] <= byte_data;
      end
      if (w_xfer && (r_state == LEN_LO)) begin
        r_len[7:0] <= byte_data;
        if (w_len_ovf) r_error <= 1'b1;
      end
      // Address wraps to 0 only after the last word of a full-depth load.
      if (r_state == WRITE) begin
        r_wr_addr    <= r_wr_addr + 1'b1;
        r_word_count <= w_cnt_inc;
      end
    end
  end

  assign byte_ready = w_ready;
  assign wr_addr    = r_wr_addr;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory. Accepts a byte stream over a valid/ready handshake and packs it into 32-bit words, most significant byte first. Issues one-cycle write strobes at consecutive word addresses starting at 0. Sits between the program-load path (testbench driver or UART receiver) and the write port of the 256-word instruction store that the fetch stage reads by pc.

Parameters:
DEPTH, 256, number of 32-bit words in the instruction store
ADDR_W, 8, word-address width; must satisfy 2**ADDR_W == DEPTH

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a load; honoured only in IDLE
byte_valid  input  1  byte_data holds a valid byte
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle; transfer = byte_valid & byte_ready
wr_en  output  1  one-cycle write strobe to the instruction store
wr_addr  output  ADDR_W  word address for the write
wr_data  output  32  assembled instruction word
busy  output  1  high in LEN_HI, LEN_LO, DATA, WRITE
done  output  1  one-cycle pulse when a load completes
error  output  1  sticky length-overflow flag
word_count  output  ADDR_W+1  words written in the current or last load

Behaviour:
- Reset (synchronous, checked every edge): state=IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, word_count=0; byte counter=0, length register=0. A partial word is discarded. Reset wins over every other input in the same cycle.
- Stream format: 2-byte big-endian word count N, followed by N*4 data bytes, each word MSB first.
- States:
  - IDLE: byte_ready=0. When start=1: clear error, word_count, wr_addr and the byte counter, then go to LEN_HI.
  - LEN_HI: byte_ready=1. On transfer, N[15:8]=byte, then go to LEN_LO.
  - LEN_LO: byte_ready=1. On transfer, N[7:0]=byte. Next state depends on the complete N:
    - N==0: go to DONE.
    - N>DEPTH: set error and go to IDLE. No done pulse; the remaining stream is not consumed.
    - Otherwise: go to DATA.
  - DATA: byte_ready=1. Each transfer shifts the byte into the low end of the word shift register and increments the 2-bit byte counter. On the 4th transfer, go to WRITE.
  - WRITE: byte_ready=0. wr_en=1 for exactly this cycle, with wr_data equal to the 4 bytes just received and wr_addr equal to the current word index. On the following edge:
    - word_count increments and wr_addr increments.
    - If word_count+1==N, go to DONE; otherwise return to DATA.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Latency: wr_en is asserted in the cycle after the 4th byte's transfer. Peak throughput is 4 bytes per 5 cycles.
- Gaps in byte_valid stall the FSM with no state change. byte_data is ignored when there is no transfer.
- start is ignored while busy or in DONE.
- wr_addr never wraps within a load because N<=DEPTH. On a load of exactly DEPTH words the last write goes to DEPTH-1. After the final increment, wr_addr reads 0 (mod 2**ADDR_W) and word_count reads DEPTH.
- error stays set until reset or the next accepted start.
- wr_en is never asserted outside WRITE.

Decomposition:
- Shared package `imem_pkg`:
  - state encoding constants: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE (3-bit)
  - IMEM_DEPTH=256, IMEM_ADDR_W=8, INSTR_W=32, shared with the instruction store
- One sub-module, `byte_packer`: 8-bit to 32-bit shift register plus 2-bit counter.
  - Inputs: clk, reset, shift_en, clear, byte_in.
  - Outputs: word_out, last_byte (counter==3 & shift_en).
  - The FSM stays in imem_loader.

Test Plan:
- Basic load: start, then stream 00 02 | 8C 01 00 04 | 08 00 00 05 with byte_valid held high.
  - wr_en at addr 0 with data 0x8C010004.
  - wr_en at addr 1 with data 0x08000005.
  - done pulses 1 cycle after the second WRITE; word_count=2; error=0.
- Zero length: start, stream 00 00 -> done pulses, no wr_en, word_count=0.
- Overflow: start, stream 01 01 (N=257) -> error=1, state IDLE, byte_ready=0, no wr_en, no done. A following start clears error.
- Backpressure and idle input:
  - N=1 word 0xDEADBEEF with byte_valid low 3 cycles between every byte -> single wr_en with 0xDEADBEEF at addr 0.
  - start pulsed mid-load -> ignored.
- Reset mid-word: N=2, deliver 6 data bytes, assert reset for 1 cycle.
  - All outputs 0, and no wr_en at addr 1.
  - A fresh load of N=1 then writes addr 0.
- Full depth: N=256 with word i = i.
  - 256 wr_en strobes at addresses 0..255, data matching.
  - Final word_count=256, done pulse once, error=0.
